// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// pc_pkg : redirect kinds, default parameters and the request priority encoder
// Rev 1.0
// ============================================================================
package pc_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_STEP      = 4;
  localparam int DEF_RESET_VEC = 0;
  localparam int DEF_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,
    PC_SEQ    = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JUMP   = 3'd3,
    PC_CALL   = 3'd4,
    PC_RET    = 3'd5
  } pc_kind_e;

  // Highest-priority request wins; everything below it is dropped.
  function automatic pc_kind_e pc_select(input logic stall, input logic ret,
                                         input logic call, input logic jump,
                                         input logic branch);
    if (stall)       return PC_HOLD;
    else if (ret)    return PC_RET;
    else if (call)   return PC_CALL;
    else if (jump)   return PC_JUMP;
    else if (branch) return PC_BRANCH;
    else             return PC_SEQ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// pc_ras : circular return-address LIFO; a push when full overwrites the oldest
// Rev 1.0
// ============================================================================
module pc_ras
  import pc_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_FULL);
  assign top_o   = mem_q[sp_q - PTR_W'(1)];

  // sp_q is the next write slot; when full it also addresses the oldest entry.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push_i) begin
      sp_d = sp_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_i) mem_q[sp_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : program counter with branch/jump/call/return redirects.
// Return-address stack present only when PC_RAS_EN is defined.   Rev 1.0
// ============================================================================
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                STEP      = DEF_STEP,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter int                RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  pc_kind_e          kind;
  logic              ret_req;
  logic [ADDR_W-1:0] pc_q, pc_d, ret_pc;

  assign pc      = pc_q;
  assign next_pc = pc_q + STEP_V;
  // Without the stack a return request simply does not exist.
  assign ret_req = ret_en & RAS_ON;
  assign kind    = pc_select(stall, ret_req, call_en, jump_en, branch_en);

  always_comb begin
    pc_d = pc_q;
    case (kind)
      PC_HOLD:          pc_d = pc_q;
      PC_SEQ:           pc_d = next_pc;
      PC_BRANCH:        pc_d = pc_q + branch_offset;
      PC_JUMP, PC_CALL: pc_d = jump_target;
      PC_RET:           pc_d = ret_pc;
      default:          pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_VEC;
    else        pc_q <= pc_d;
  end

`ifdef PC_RAS_EN
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ovf_q, unf_q;

  assign ras_push = (kind == PC_CALL);
  assign ras_pop  = (kind == PC_RET) && !ras_empty;
  // Return with nothing stacked falls through to the sequential address.
  assign ret_pc   = ras_empty ? next_pc : ras_top;

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (ras_push),
    .pop_i  (ras_pop),
    .data_i (next_pc),
    .top_o  (ras_top),
    .empty_o(ras_empty),
    .full_o (ras_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ras_push && ras_full;
      unf_q <= (kind == PC_RET) && ras_empty;
    end
  end

  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
`else
  assign ret_pc    = next_pc;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

endmodule
`default_nettype wire
